// File: rtl/io_input_port.sv
// Handshake bridge from the byte source io_input to the subleq core read path.
// Optional IO_INPUT_SYNC_EN adds a 2-flop synchronizer on io_ack.
module io_input_port #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] EOF_VALUE = {WORD_SIZE{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     io_req,
  input  logic                     io_ack,
  input  logic                     io_eof,
  input  logic [WORD_SIZE-1:0]     io_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WORD_SIZE-1:0]     rd_data,
  output logic                     at_eof,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP,
    EOF
  } state_t;

  state_t state;
  state_t state_n;

  logic ack_s;
  logic push;
  logic eof_hit;
  logic req_n;
  logic pop;
  logic eof_rd;
  logic svc;
  logic has_space;
  logic empty;
  logic eof_seen;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] byte_word;

  logic unused_hi;
  assign unused_hi = ^io_data[WORD_SIZE-1:8];

`ifdef IO_INPUT_SYNC_EN
  logic ack_m;
  logic ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_m <= io_ack;
      ack_q <= ack_m;
    end
  end

  assign ack_s = ack_q;
`else
  assign ack_s = io_ack;
`endif

  assign has_space = count < CW'(DEPTH);
  assign empty     = count == '0;
  assign byte_word = {{(WORD_SIZE-8){1'b0}}, io_data[7:0]};

  // State register; reset lands in DROP so a stale ack is waited out.
  always_ff @(posedge clk) begin
    if (rst) state <= DROP;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (has_space) state_n = REQ;
      REQ:  if (ack_s) state_n = DROP;
      DROP: if (!ack_s) state_n = eof_seen ? EOF : IDLE;
      EOF:  state_n = EOF;
      default: state_n = DROP;
    endcase
  end

  always_comb begin
    push    = 1'b0;
    eof_hit = 1'b0;
    req_n   = 1'b0;
    unique case (state)
      IDLE: req_n = has_space;
      REQ: begin
        push    = ack_s && !io_eof;
        eof_hit = ack_s && io_eof;
        req_n   = !ack_s;
      end
      DROP: req_n = 1'b0;
      EOF:  req_n = 1'b0;
      default: req_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) io_req <= 1'b0;
    else     io_req <= req_n;
  end

  // A read is taken only when no result is in flight.
  assign svc    = rd_en && !rd_valid;
  assign pop    = svc && !empty;
  assign eof_rd = svc && empty && eof_seen;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= byte_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      eof_seen <= 1'b0;
      at_eof   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (eof_hit) eof_seen <= 1'b1;
      at_eof   <= eof_seen && empty;
      rd_valid <= pop || eof_rd;
      if (pop)         rd_data <= mem[rptr];
      else if (eof_rd) rd_data <= EOF_VALUE;
    end
  end

endmodule

// File: doc/io_input_port.md
# io_input_port

Clocked bridge between the behavioural byte source `io_input` and the subleq core's input read path. It drives the source's 4-phase `req`/`ack` handshake and prefetches bytes into a small FIFO. It latches end-of-file and serves the core one word per read strobe, returning a fixed EOF word once input is exhausted and the FIFO is drained.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `EOF_VALUE`, all ones (`{`WORD_SIZE{1'b1}}`): word returned on reads after EOF with the FIFO empty.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `io_req`  out  1  request to byte source; registered.
- `io_ack`  in  1  acknowledge from byte source; asynchronous to `clk`.
- `io_eof`  in  1  source EOF flag; valid while `io_ack`=1.
- `io_data`  in  `WORD_SIZE`  source data; valid while `io_ack`=1.
- `rd_en`  in  1  core read request (level).
- `rd_valid`  out  1  one-cycle pulse: `rd_data` valid.
- `rd_data`  out  `WORD_SIZE`  word returned to core; registered.
- `at_eof`  out  1  EOF latched **and** FIFO empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Handshake FSM states: `IDLE`, `REQ`, `DROP`, `EOF`.
- `IDLE`: if `count<DEPTH`, set `io_req`=1 and go to `REQ`. Otherwise stay.
- `REQ`: on sampled `ack_s`=1:
  - If `io_eof`=1: set `eof_seen` and push nothing.
  - Else: push `{0, io_data[7:0]}`. Upper bits are forced to zero.
  - In both cases clear `io_req` and go to `DROP`.
- `DROP`: on `ack_s`=0, go to `EOF` if `eof_seen`, else `IDLE`.
- `EOF`: terminal. `io_req` held 0 until `rst`.
- Read side: a read is serviced in a cycle where `rd_en`=1 and `rd_valid`=0. Holding `rd_en` high never double-pops.
  - FIFO non-empty: pop head into `rd_data`; `rd_valid`=1 the next cycle.
  - FIFO empty, `eof_seen`=1: `rd_data`=`EOF_VALUE`; `rd_valid`=1 the next cycle; no pop.
  - FIFO empty, `eof_seen`=0: no action. The core keeps `rd_en` high and stalls.
- Push and pop in the same cycle: both happen; `count` unchanged. Pointers wrap modulo `DEPTH`.
- `rd_data` holds its last value when `rd_valid`=0.

## Timing
- Reset values:
  - `io_req`=0, `rd_valid`=0, `rd_data`=0, `at_eof`=0, `count`=0.
  - Pointers=0, `eof_seen`=0; synchronizer flops=0.
  - FSM=`DROP`.
- Reset into `DROP` means a stale `io_ack` left high by reset mid-handshake is waited out. No `io_req` is issued until `ack_s`=0.
- `io_req` rises 1 cycle after entering `IDLE` with space.
- Data is captured on the edge where `ack_s`=1 is first seen. `io_req` falls on that same edge.
- Read latency: `rd_valid` 1 cycle after the servicing `rd_en` cycle. Throughput: one read per 2 cycles.
- A byte pushed at edge N is poppable by a read at edge N+1. There is no same-cycle bypass of an empty FIFO.
- `at_eof` is registered and updates the cycle after the last pop or after `eof_seen` sets.

## Configuration
- `IO_INPUT_SYNC_EN` defined:
  - `ack_s` is `io_ack` passed through a 2-flop synchronizer.
  - Adds 2 cycles to each ack edge detection (rise and fall).
  - `io_data` and `io_eof` are sampled directly; the source holds them stable while `io_ack`=1.
- Undefined:
  - `ack_s`=`io_ack` directly, for the simulation-only behavioural source.
  - Handshake round-trip drops by 4 cycles.
  - All other behaviour is identical.

## Test plan
- Source supplies bytes 0x41, 0x42, 0x43, then EOF; core reads 5 times:
  - `rd_data` = 0x41, 0x42, 0x43, `EOF_VALUE`, `EOF_VALUE`.
  - `at_eof`=1 after the third read.
  - `io_req` never rises after EOF.
- Core idle while source has 10 bytes (`DEPTH`=4):
  - `count` saturates at 4 and `io_req` stays 0.
  - One read gives `count`=3, then one new `io_req` cycle refills to 4.
- Core holds `rd_en`=1 for 6 cycles with 2 bytes buffered:
  - Exactly 2 `rd_valid` pulses, on alternate cycles, data in order.
  - Thereafter no pulses while the FIFO is empty without EOF.
- Push and pop on the same edge with `count`=2: `count` stays 2 and data order is preserved.
- Assert `rst` for one cycle while in `REQ` with `io_ack`=1:
  - `io_req`=0 the next cycle.
  - No push of that byte.
  - Next `io_req` only after `io_ack` is seen low.
- With `IO_INPUT_SYNC_EN` defined vs undefined: identical `rd_data` sequences; per-byte handshake latency differs by 4 cycles.
